stepper_phase_decoder: RTL and testbench



---
 rtl/stepper_phase_decoder.sv | 201 ++++++++++++++++++++
 tb/tb_stepper_phase_decoder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_phase_decoder.sv
// Stepper coil-phase decoder.
// Watches the 4-bit coil pattern that drives a stepper motor and works out the motion from it:
// step events, direction and a signed position count. It also flags illegal patterns and
// transitions. Its place is beside the controller or at the far end of the coil bus, where it
// serves as an independent position check.
module stepper_phase_decoder #(
    parameter int POS_W    = 16,
    parameter int FILT_CYC = 2,
    parameter int IDLE_CYC = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [3:0]       phase_in,
    input  logic             clear_pos,
    input  logic             clear_err,
    output logic [POS_W-1:0] position,
    output logic             dir,
    output logic             step_pulse,
    output logic             moving,
    output logic             locked,
    output logic             err_pulse,
    output logic             err_sticky
);

    localparam logic [3:0]  FILT_N = 4'(FILT_CYC);
    localparam logic [15:0] IDLE_N = 16'(IDLE_CYC);

    typedef enum logic [1:0] {
        ST_ACQUIRE,
        ST_TRACK,
        ST_FAULT
    } state_t;

    state_t     r_state;
    logic [3:0] r_sync;
    logic [3:0] r_cand;
    logic [3:0] r_filt_cnt;
    logic       r_acc;
    logic [3:0] r_acc_pat;
    logic       r_en_d;
    logic [2:0] r_ref;
    logic [15:0] r_idle;

    logic             w_valid;
    logic             w_off;
    logic             w_invalid;
    logic [2:0]       w_idx;
    logic [2:0]       w_delta;
    logic             w_legal_delta;
    logic             w_bad_delta;
    logic [POS_W-1:0] w_step_val;
    logic             w_en_rise;
    logic             w_evt;
    logic             w_step;
    logic             w_err;

    // Decode the accepted pattern into a half-step index, OFF or INVALID.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        w_idx   = 3'd0;
        w_valid = 1'b1;
        w_off   = 1'b0;
        case (r_acc_pat)
            4'b1000: w_idx = 3'd0;
            4'b1100: w_idx = 3'd1;
            4'b0100: w_idx = 3'd2;
            4'b0110: w_idx = 3'd3;
            4'b0010: w_idx = 3'd4;
            4'b0011: w_idx = 3'd5;
            4'b0001: w_idx = 3'd6;
            4'b1001: w_idx = 3'd7;
            4'b0000: begin
                w_valid = 1'b0;
                w_off   = 1'b1;
            end
            default: w_valid = 1'b0;
        endcase
    end

    assign w_invalid = ~w_valid & ~w_off;

    // The modulo-8 delta is read as a signed 3-bit value. The values 1, 2, 6 and 7 mean
    // +1, +2, -2 and -1. The values 3, 4 and 5 are too far for the drive to have produced,
    // so they are illegal.
    assign w_delta       = w_idx - r_ref;
    assign w_legal_delta = (w_delta == 3'd1) || (w_delta == 3'd2) ||
                           (w_delta == 3'd6) || (w_delta == 3'd7);
    assign w_bad_delta   = (w_delta == 3'd3) || (w_delta == 3'd4) || (w_delta == 3'd5);
    assign w_step_val    = {{(POS_W-3){w_delta[2]}}, w_delta};

    assign w_en_rise = enable & ~r_en_d;
    assign w_evt     = enable & ~w_en_rise & r_acc;
    assign w_step    = w_evt & (r_state == ST_TRACK) & w_valid & w_legal_delta;
    assign w_err     = w_evt & (w_invalid | ((r_state == ST_TRACK) & w_valid & w_bad_delta));

    // Sync stage followed by a stability filter.
    // A one-cycle acceptance strobe fires when the filter count reaches FILT_CYC.
    always_ff @(posedge clk) begin
        // NOTE: every register in this design is a small control register, so every one of them
        // gets a reset value. All sequential state uses non-blocking assignments.
        if (reset) begin
            r_sync     <= 4'd0;
            r_cand     <= 4'd0;
            r_filt_cnt <= 4'd0;
            r_acc      <= 1'b0;
            r_acc_pat  <= 4'd0;
            r_en_d     <= 1'b1;
        end else begin
            r_sync <= phase_in;
            r_en_d <= enable;
            if (w_en_rise) begin
                r_cand     <= 4'd0;
                r_filt_cnt <= 4'd0;
                r_acc      <= 1'b0;
            end else if (!enable) begin
                r_acc <= 1'b0;
            end else if (r_sync != r_cand) begin
                r_cand     <= r_sync;
                r_filt_cnt <= 4'd1;
                r_acc      <= (FILT_N == 4'd1);
                r_acc_pat  <= r_sync;
            end else if (r_filt_cnt < FILT_N) begin
                r_filt_cnt <= r_filt_cnt + 4'd1;
                r_acc      <= (r_filt_cnt + 4'd1 == FILT_N);
                r_acc_pat  <= r_cand;
            end else begin
                r_acc <= 1'b0;
            end
        end
    end

    // Tracking FSM with registered outputs: position, direction, strobes, error and idle timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_ACQUIRE;
            r_ref      <= 3'd0;
            r_idle     <= 16'd0;
            position   <= '0;
            dir        <= 1'b0;
            step_pulse <= 1'b0;
            moving     <= 1'b0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            step_pulse <= w_step;
            err_pulse  <= w_err;

            if (w_err)
                err_sticky <= 1'b1;
            else if (clear_err)
                err_sticky <= 1'b0;

            if (clear_pos)
                position <= '0;
            else if (w_step)
                position <= position + w_step_val;

            if (w_step)
                dir <= ~w_delta[2];

            if (w_step) begin
                r_idle <= IDLE_N;
                moving <= 1'b1;
            end else if (r_idle != 16'd0) begin
                r_idle <= r_idle - 16'd1;
                moving <= (r_idle != 16'd1);
            end

            if (w_en_rise) begin
                r_state <= ST_ACQUIRE;
                locked  <= 1'b0;
            end else if (w_evt) begin
                case (r_state)
                    ST_ACQUIRE, ST_FAULT: begin
                        if (w_valid) begin
                            r_ref   <= w_idx;
                            r_state <= ST_TRACK;
                            locked  <= 1'b1;
                        end
                    end
                    ST_TRACK: begin
                        if (w_err) begin
                            r_state <= ST_FAULT;
                            locked  <= 1'b0;
                        end else if (w_valid) begin
                            r_ref <= w_idx;
                        end
                    end
                    default: begin
                        r_state <= ST_ACQUIRE;
                        locked  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Testbench for stepper_phase_decoder.
// Two instances run from one clock: the default POS_W=16 unit and a POS_W=4 unit for the
// wrap-around case. Stimulus pushes each expected pulse (step or error) into a queue, tagged
// with the cycle it is due on. A monitor for each unit pops and compares whenever a pulse is
// due or one appears.
module tb_stepper_phase_decoder;

    localparam int K_NONE = 0;
    localparam int K_STEP = 1;
    localparam int K_ERR  = 2;

    typedef struct {
        logic        is_err;
        logic [15:0] pos;
        logic        dir;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Unit 0 (POS_W = 16).
    logic        enable, clear_pos, clear_err;
    logic [3:0]  phase_in;
    logic [15:0] position;
    logic        dir, step_pulse, moving, locked, err_pulse, err_sticky;

    // Unit 1 (POS_W = 4).
    logic        clear_pos_4;
    logic [3:0]  phase_4;
    logic [3:0]  position_4;
    logic        dir_4, step_pulse_4, moving_4, locked_4, err_pulse_4, err_sticky_4;

    exp_t q0[$];
    exp_t q1[$];

    logic [3:0] fwd_pat [0:7] = '{4'b1100, 4'b0100, 4'b0110, 4'b0010,
                                  4'b0011, 4'b0001, 4'b1001, 4'b1000};

    stepper_phase_decoder dut (
        .clk(clk), .reset(reset), .enable(enable), .phase_in(phase_in),
        .clear_pos(clear_pos), .clear_err(clear_err), .position(position),
        .dir(dir), .step_pulse(step_pulse), .moving(moving), .locked(locked),
        .err_pulse(err_pulse), .err_sticky(err_sticky)
    );

    stepper_phase_decoder #(.POS_W(4)) dut4 (
        .clk(clk), .reset(reset), .enable(1'b1), .phase_in(phase_4),
        .clear_pos(clear_pos_4), .clear_err(1'b0), .position(position_4),
        .dir(dir_4), .step_pulse(step_pulse_4), .moving(moving_4), .locked(locked_4),
        .err_pulse(err_pulse_4), .err_sticky(err_sticky_4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Drive a pattern on unit 0. Queue the pulse it should cause, then hold the pattern for n cycles.
    // The pulse is due 4 edges after the drive point: 1 sync edge + FILT_CYC filter edges + 1 output edge.
    task automatic apply(input logic [3:0] p, input int n, input int kind,
                         input logic [15:0] pos, input logic d);
        exp_t e;
        phase_in = p;
        if (kind != K_NONE) begin
            e.is_err = (kind == K_ERR);
            e.pos    = pos;
            e.dir    = d;
            e.cyc    = cyc + 4;
            q0.push_back(e);
        end
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic apply4(input logic [3:0] p, input int n, input int kind,
                          input logic [15:0] pos, input logic d);
        exp_t e;
        phase_4 = p;
        if (kind != K_NONE) begin
            e.is_err = (kind == K_ERR);
            e.pos    = pos;
            e.dir    = d;
            e.cyc    = cyc + 4;
            q1.push_back(e);
        end
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Monitor for unit 0: compare a due pulse, or flag a pulse that nothing expected.
    always @(negedge clk) begin
        exp_t e;
        if (q0.size() != 0 && q0[0].cyc == cyc) begin
            e = q0.pop_front();
            check("u0 pulse present", 32'(step_pulse | err_pulse), 32'd1);
            check("u0 pulse kind err", 32'(err_pulse), 32'(e.is_err));
            check("u0 position", 32'(position), 32'(e.pos));
            check("u0 dir", 32'(dir), 32'(e.dir));
        end else if (step_pulse || err_pulse) begin
            check("u0 unexpected pulse", 32'({step_pulse, err_pulse}), 32'd0);
        end
    end

    // Monitor for unit 1.
    always @(negedge clk) begin
        exp_t e;
        if (q1.size() != 0 && q1[0].cyc == cyc) begin
            e = q1.pop_front();
            check("u1 pulse present", 32'(step_pulse_4 | err_pulse_4), 32'd1);
            check("u1 pulse kind err", 32'(err_pulse_4), 32'(e.is_err));
            check("u1 position", 32'(position_4), 32'(e.pos[3:0]));
            check("u1 dir", 32'(dir_4), 32'(e.dir));
        end else if (step_pulse_4 || err_pulse_4) begin
            check("u1 unexpected pulse", 32'({step_pulse_4, err_pulse_4}), 32'd0);
        end
    end

    initial begin
        reset       = 1'b1;
        enable      = 1'b1;
        clear_pos   = 1'b0;
        clear_err   = 1'b0;
        clear_pos_4 = 1'b0;
        phase_in    = 4'b0000;
        phase_4     = 4'b0000;
        repeat (3) begin @(posedge clk); #1; end

        // Reset values.
        check("rst position", 32'(position), 32'd0);
        check("rst dir", 32'(dir), 32'd0);
        check("rst step_pulse", 32'(step_pulse), 32'd0);
        check("rst moving", 32'(moving), 32'd0);
        check("rst locked", 32'(locked), 32'd0);
        check("rst err_pulse", 32'(err_pulse), 32'd0);
        check("rst err_sticky", 32'(err_sticky), 32'd0);
        reset = 1'b0;

        // Acquire on index 0, then three forward half-steps.
        apply(4'b1000, 5, K_NONE, 16'd0, 1'b0);
        check("acq locked", 32'(locked), 32'd1);
        check("acq position", 32'(position), 32'd0);
        apply(4'b1100, 4, K_STEP, 16'd1, 1'b1);
        apply(4'b0100, 4, K_STEP, 16'd2, 1'b1);
        apply(4'b0110, 4, K_STEP, 16'd3, 1'b1);
        check("fwd position", 32'(position), 32'd3);
        check("fwd dir", 32'(dir), 32'd1);
        check("fwd moving", 32'(moving), 32'd1);

        // Reverse to -1, then index 7 -> 3 (delta 4): illegal, position frozen.
        apply(4'b0100, 4, K_STEP, 16'd2, 1'b0);
        apply(4'b1100, 4, K_STEP, 16'd1, 1'b0);
        apply(4'b1000, 4, K_STEP, 16'd0, 1'b0);
        apply(4'b1001, 4, K_STEP, 16'hFFFF, 1'b0);
        apply(4'b0110, 5, K_ERR, 16'hFFFF, 1'b0);
        check("delta4 err_sticky", 32'(err_sticky), 32'd1);
        check("delta4 locked", 32'(locked), 32'd0);
        check("delta4 position", 32'(position), 32'hFFFF);

        // Recover from FAULT on index 0 without counting.
        apply(4'b1000, 5, K_NONE, 16'd0, 1'b0);
        check("recover locked", 32'(locked), 32'd1);
        check("recover position", 32'(position), 32'hFFFF);

        // One-cycle glitch is ignored; a two-cycle-stable pattern counts.
        apply(4'b0110, 1, K_NONE, 16'd0, 1'b0);
        apply(4'b1000, 5, K_NONE, 16'd0, 1'b0);
        apply(4'b1100, 2, K_STEP, 16'd0, 1'b1);
        apply(4'b0100, 4, K_STEP, 16'd1, 1'b1);

        // Illegal pattern: FAULT, then a repeated pulse for another invalid pattern.
        apply(4'b1111, 5, K_ERR, 16'd1, 1'b1);
        check("invalid locked", 32'(locked), 32'd0);
        apply(4'b1110, 5, K_ERR, 16'd1, 1'b1);
        apply(4'b0010, 5, K_NONE, 16'd0, 1'b0);
        check("refault locked", 32'(locked), 32'd1);
        check("refault position", 32'(position), 32'd1);
        check("sticky held", 32'(err_sticky), 32'd1);
        clear_err = 1'b1;
        @(posedge clk); #1;
        clear_err = 1'b0;
        check("clear_err", 32'(err_sticky), 32'd0);

        // Full-step back, a half-step, then OFF: the reference is retained and moving times out.
        apply(4'b0100, 4, K_STEP, 16'hFFFF, 1'b0);
        apply(4'b1100, 4, K_STEP, 16'hFFFE, 1'b0);
        apply(4'b0000, 15, K_NONE, 16'd0, 1'b0);
        check("moving at +15", 32'(moving), 32'd1);
        @(posedge clk); #1;
        check("moving at +16", 32'(moving), 32'd0);
        repeat (4) begin @(posedge clk); #1; end
        apply(4'b0100, 4, K_STEP, 16'hFFFF, 1'b1);
        check("after off moving", 32'(moving), 32'd1);

        // Disabled: input is ignored and state is held, but clear_pos still acts.
        // On re-enable the unit re-acquires without counting.
        enable = 1'b0;
        apply(4'b0110, 6, K_NONE, 16'd0, 1'b0);
        check("disabled locked", 32'(locked), 32'd1);
        check("disabled position", 32'(position), 32'hFFFF);
        clear_pos = 1'b1;
        @(posedge clk); #1;
        clear_pos = 1'b0;
        check("disabled clear_pos", 32'(position), 32'd0);
        enable = 1'b1;
        @(posedge clk); #1;
        check("enable rise locked", 32'(locked), 32'd0);
        repeat (5) begin @(posedge clk); #1; end
        check("reacquire locked", 32'(locked), 32'd1);
        check("reacquire position", 32'(position), 32'd0);

        // POS_W=4: eight forward half-steps wrap 7 -> -8.
        apply4(4'b1000, 5, K_NONE, 16'd0, 1'b0);
        for (int i = 0; i < 8; i++)
            apply4(fwd_pat[i], 4, K_STEP, 16'(i + 1), 1'b1);
        check("u1 wrap position", 32'(position_4), 32'h8);
        check("u1 wrap no error", 32'(err_sticky_4), 32'd0);

        // clear_pos on the same edge as a step: position clears, the pulse still fires.
        phase_4 = 4'b1100;
        begin
            exp_t e;
            e.is_err = 1'b0;
            e.pos    = 16'd0;
            e.dir    = 1'b1;
            e.cyc    = cyc + 4;
            q1.push_back(e);
        end
        repeat (3) begin @(posedge clk); #1; end
        clear_pos_4 = 1'b1;
        @(posedge clk); #1;
        clear_pos_4 = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("u1 clear_pos position", 32'(position_4), 32'd0);

        // Reset while a step is in flight discards it.
        phase_4 = 4'b0100;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        check("u1 midrst position", 32'(position_4), 32'd0);
        check("u1 midrst dir", 32'(dir_4), 32'd0);
        check("u1 midrst step_pulse", 32'(step_pulse_4), 32'd0);
        check("u1 midrst moving", 32'(moving_4), 32'd0);
        check("u1 midrst locked", 32'(locked_4), 32'd0);
        check("u1 midrst err_pulse", 32'(err_pulse_4), 32'd0);
        check("u1 midrst err_sticky", 32'(err_sticky_4), 32'd0);
        reset = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        check("u1 post-rst locked", 32'(locked_4), 32'd1);
        check("u1 post-rst position", 32'(position_4), 32'd0);

        repeat (5) begin @(posedge clk); #1; end
        check("u0 queue drained", 32'(q0.size()), 32'd0);
        check("u1 queue drained", 32'(q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
